// File: rtl/sa_sched_pkg.sv
// Shared types and default widths for the systolic-array job scheduler.
package sa_sched_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int ID_W_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        RUN,
        DONE,
        FLUSH
    } state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] base_a;
        logic [ADDR_W_DEF-1:0] base_b;
        logic [ID_W_DEF-1:0]   id;
    } job_t;

endpackage

// File: rtl/sa_job_fifo.sv
// Synchronous job FIFO with flush; pointers wrap naturally because DEPTH is a power of two.
module sa_job_fifo
    import sa_sched_pkg::*;
#(
    parameter type entry_t = job_t,
    parameter int  DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    input  logic             flush,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sa_job_scheduler.sv
// Job scheduler for the mem_fifo_sa datapath: queues jobs, then clears, launches,
// times and reports each one in order.
module sa_job_scheduler
    import sa_sched_pkg::*;
#(
    parameter int  DIM        = 5,
    parameter int  ADDR_W     = ADDR_W_DEF,
    parameter int  ID_W       = ID_W_DEF,
    parameter int  QDEPTH     = 4,
    parameter int  RUN_CYCLES = 3*DIM - 1,
    localparam int QCNT_W     = $clog2(QDEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_base_a,
    input  logic [ADDR_W-1:0] job_base_b,
    input  logic [ID_W-1:0]   job_id,
    input  logic              abort,
    output logic              sa_clr,
    output logic              sa_init,
    output logic [ADDR_W-1:0] sa_base_a,
    output logic [ADDR_W-1:0] sa_base_b,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [ID_W-1:0]   done_id,
    output logic              busy,
    output logic [QCNT_W-1:0] q_count
);

    localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] base_a;
        logic [ADDR_W-1:0] base_b;
        logic [ID_W-1:0]   id;
    } entry_t;

    state_t           state;
    state_t           state_nxt;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_nxt;
    logic             q_push;
    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    entry_t           q_in;
    entry_t           q_head;

    assign job_ready = !q_full && !abort;
    assign q_push    = job_valid && job_ready;
    assign q_in      = '{base_a: job_base_a, base_b: job_base_b, id: job_id};

    sa_job_fifo #(
        .entry_t (entry_t),
        .DEPTH   (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .flush     (abort),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // abort wins over every state so the datapath always gets a final clear.
    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        q_pop       = 1'b0;
        if (abort) begin
            state_nxt = FLUSH;
        end else begin
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        q_pop     = 1'b1;
                        state_nxt = CLEAR;
                    end
                end
                CLEAR:  state_nxt = LAUNCH;
                LAUNCH: begin
                    run_cnt_nxt = RUN_W'(RUN_CYCLES - 1);
                    state_nxt   = RUN;
                end
                RUN: begin
                    if (run_cnt == '0) state_nxt = DONE;
                    else               run_cnt_nxt = run_cnt - 1'b1;
                end
                DONE: begin
                    if (done_ready) state_nxt = IDLE;
                end
                FLUSH:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            run_cnt   <= '0;
            sa_base_a <= '0;
            sa_base_b <= '0;
            done_id   <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_cnt_nxt;
            if (q_pop) begin
                sa_base_a <= q_head.base_a;
                sa_base_b <= q_head.base_b;
                done_id   <= q_head.id;
            end
        end
    end

    // Decoded straight from state so an async reset clears them at once.
    assign sa_clr     = (state == CLEAR) || (state == FLUSH);
    assign sa_init    = (state == LAUNCH);
    assign done_valid = (state == DONE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sa_job_scheduler.sv
// Self-checking bench for sa_job_scheduler: directed scenarios plus random traffic
// compared every cycle against a time-offset job model.
module tb_sa_job_scheduler;

    localparam int QDEPTH = 4;
    localparam int RUN    = 14;

    logic       clk;
    logic       rst;
    logic       job_valid;
    logic       job_ready;
    logic [7:0] job_base_a;
    logic [7:0] job_base_b;
    logic [3:0] job_id;
    logic       abort;
    logic       sa_clr;
    logic       sa_init;
    logic [7:0] sa_base_a;
    logic [7:0] sa_base_b;
    logic       done_valid;
    logic       done_ready;
    logic [3:0] done_id;
    logic       busy;
    logic [2:0] q_count;

    sa_job_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_base_a (job_base_a),
        .job_base_b (job_base_b),
        .job_id     (job_id),
        .abort      (abort),
        .sa_clr     (sa_clr),
        .sa_init    (sa_init),
        .sa_base_a  (sa_base_a),
        .sa_base_b  (sa_base_b),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_id    (done_id),
        .busy       (busy),
        .q_count    (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: queue of waiting jobs, plus the in-flight job described by the
    // number of cycles since it was popped (0 clear, 1 launch, RUN+2 results ready).
    typedef struct {
        int a;
        int b;
        int id;
    } mjob_t;

    mjob_t mq[$];
    bit    m_active;
    bit    m_flush;
    int    m_t;
    int    m_a;
    int    m_b;
    int    m_id;
    bit    m_pushed;

    int cyc = 0;
    int ev_clr, ev_init, ev_done, cnt_clr;
    bit prev_done;
    int done_log[$];
    int done_a_log[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_flush  = 0;
        m_t      = 0;
        m_a      = 0;
        m_b      = 0;
        m_id     = 0;
        prev_done = 0;
    endtask

    task automatic clear_ev();
        ev_clr  = -1;
        ev_init = -1;
        ev_done = -1;
        cnt_clr = 0;
        done_log.delete();
        done_a_log.delete();
    endtask

    task automatic check_outputs();
        bit exp_done;
        exp_done = m_active && (m_t >= RUN + 2);
        chk("busy",       int'(busy),       int'(m_active || m_flush));
        chk("sa_clr",     int'(sa_clr),     int'(m_flush || (m_active && m_t == 0)));
        chk("sa_init",    int'(sa_init),    int'(m_active && m_t == 1));
        chk("done_valid", int'(done_valid), int'(exp_done));
        chk("sa_base_a",  int'(sa_base_a),  m_a);
        chk("sa_base_b",  int'(sa_base_b),  m_b);
        chk("done_id",    int'(done_id),    m_id);
        chk("q_count",    int'(q_count),    mq.size());
        chk("job_ready",  int'(job_ready),  int'((mq.size() < QDEPTH) && !abort));
        if (sa_clr) begin
            cnt_clr++;
            if (ev_clr < 0) ev_clr = cyc;
        end
        if (sa_init && ev_init < 0) ev_init = cyc;
        if (done_valid && !prev_done && ev_done < 0) ev_done = cyc;
        prev_done = done_valid;
        if (done_valid && done_ready) begin
            done_log.push_back(int'(done_id));
            done_a_log.push_back(int'(sa_base_a));
        end
    endtask

    task automatic model_step();
        mjob_t j;
        bit    push;
        push     = job_valid && (mq.size() < QDEPTH) && !abort;
        m_pushed = push;
        if (abort) begin
            mq.delete();
            m_active = 0;
            m_flush  = 1;
        end else begin
            if (m_flush) begin
                m_flush = 0;
            end else if (m_active) begin
                if (m_t >= RUN + 2) begin
                    if (done_ready) m_active = 0;
                end else begin
                    m_t++;
                end
            end else if (mq.size() > 0) begin
                j        = mq.pop_front();
                m_a      = j.a;
                m_b      = j.b;
                m_id     = j.id;
                m_active = 1;
                m_t      = 0;
            end
            if (push) begin
                j.a  = int'(job_base_a);
                j.b  = int'(job_base_b);
                j.id = int'(job_id);
                mq.push_back(j);
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] id, input logic ab, input logic dr);
        job_valid  = v;
        job_base_a = a;
        job_base_b = b;
        job_id     = id;
        abort      = ab;
        done_ready = dr;
        #1;
        cyc++;
        check_outputs();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_cycle(input logic dr);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, dr);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 400 && (m_active || m_flush || mq.size() > 0); k++) idle_cycle(1'b1);
        chk("drain_timeout", int'(k < 400), 1);
    endtask

    task automatic wait_init();
        int k;
        for (k = 0; k < 20 && ev_init < 0; k++) idle_cycle(1'b1);
        chk("wait_init_timeout", int'(ev_init >= 0), 1);
    endtask

    task automatic wait_done_held();
        int k;
        for (k = 0; k < 60 && done_valid !== 1'b1; k++) idle_cycle(1'b0);
        chk("wait_done_timeout", int'(done_valid), 1);
    endtask

    int  c0;
    int  r0;
    bit  accepted;

    initial begin
        rst        = 1'b1;
        job_valid  = 1'b0;
        job_base_a = '0;
        job_base_b = '0;
        job_id     = '0;
        abort      = 1'b0;
        done_ready = 1'b0;
        model_reset();
        clear_ev();
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",    int'(busy),       0);
        chk("rst_clr",     int'(sa_clr),     0);
        chk("rst_done",    int'(done_valid), 0);
        chk("rst_q_count", int'(q_count),    0);
        rst = 1'b0;
        idle_cycle(1'b1);

        // Single job: clr, init, then results 15 cycles after init.
        clear_ev();
        c0 = cyc + 1;
        cycle(1'b1, 8'h00, 8'h00, 4'd3, 1'b0, 1'b1);
        repeat (22) idle_cycle(1'b1);
        chk("t1_clr_latency",  ev_clr - c0,       2);
        chk("t1_init_latency", ev_init - c0,      3);
        chk("t1_done_latency", ev_done - ev_init, 15);
        chk("t1_clr_pulses",   cnt_clr,           1);
        chk("t1_done_count",   done_log.size(),   1);
        if (done_log.size() > 0) chk("t1_done_id", done_log[0], 3);

        // Fill the queue behind a running job; the next push waits for a pop.
        clear_ev();
        cycle(1'b1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(16*i), 8'(i), 4'(i), 1'b0, 1'b1);
        chk("t2_q_full",  int'(q_count),   4);
        chk("t2_stalled", int'(job_ready), 0);
        accepted = 0;
        for (int k = 0; k < 100 && !accepted; k++) begin
            cycle(1'b1, 8'h50, 8'h05, 4'd5, 1'b0, 1'b1);
            accepted = m_pushed;
        end
        chk("t2_fifth_accepted", int'(accepted), 1);
        drain();
        chk("t2_done_count", done_log.size(), 6);
        for (int i = 0; i < 6 && i < done_log.size(); i++) begin
            chk("t2_order",  done_log[i],   i);
            chk("t2_base_a", done_a_log[i], 16*i);
        end

        // Consumer stalls in DONE for 10 cycles.
        clear_ev();
        cycle(1'b1, 8'h33, 8'h44, 4'd7, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 8'h66, 4'd8, 1'b0, 1'b0);
        wait_done_held();
        cnt_clr = 0;
        repeat (10) idle_cycle(1'b0);
        chk("t3_no_clear",  cnt_clr,          0);
        chk("t3_held",      int'(done_valid), 1);
        chk("t3_done_id",   int'(done_id),    7);
        chk("t3_base_a",    int'(sa_base_a),  8'h33);
        r0 = cyc + 1;
        ev_clr = -1;
        idle_cycle(1'b1);
        repeat (3) idle_cycle(1'b0);
        chk("t3_restart", ev_clr - r0, 2);
        drain();

        // Abort during RUN with two jobs waiting.
        clear_ev();
        cycle(1'b1, 8'h11, 8'h22, 4'd1, 1'b0, 1'b1);
        wait_init();
        cycle(1'b1, 8'h21, 8'h22, 4'd2, 1'b0, 1'b1);
        cycle(1'b1, 8'h31, 8'h32, 4'd3, 1'b0, 1'b1);
        chk("t4_q2", int'(q_count), 2);
        cycle(1'b1, 8'h41, 8'h42, 4'd4, 1'b1, 1'b1);
        chk("t4_flush_clr",  int'(sa_clr),  1);
        chk("t4_flush_busy", int'(busy),    1);
        chk("t4_flush_q",    int'(q_count), 0);
        idle_cycle(1'b1);
        chk("t4_q_empty", int'(q_count), 0);
        chk("t4_idle",    int'(busy),    0);
        repeat (30) idle_cycle(1'b1);
        chk("t4_no_done", done_log.size(), 0);

        // Push and pop on the same edge with two waiting.
        clear_ev();
        cycle(1'b1, 8'h90, 8'h09, 4'd9, 1'b0, 1'b0);
        wait_done_held();
        cycle(1'b1, 8'hA0, 8'h0A, 4'd10, 1'b0, 1'b0);
        cycle(1'b1, 8'hB0, 8'h0B, 4'd11, 1'b0, 1'b0);
        idle_cycle(1'b1);
        chk("t5_q_before", int'(q_count), 2);
        chk("t5_idle",     int'(busy),    0);
        cycle(1'b1, 8'hC0, 8'h0C, 4'd12, 1'b0, 1'b1);
        chk("t5_q_same",  int'(q_count),   2);
        chk("t5_oldest",  int'(sa_base_a), 8'hA0);
        chk("t5_old_id",  int'(done_id),   10);
        drain();

        // Asynchronous reset in the middle of RUN.
        clear_ev();
        cycle(1'b1, 8'h66, 8'h77, 4'd6, 1'b0, 1'b1);
        wait_init();
        cycle(1'b1, 8'h88, 8'h99, 4'd13, 1'b0, 1'b1);
        idle_cycle(1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_busy",    int'(busy),       0);
        chk("t6_clr",     int'(sa_clr),     0);
        chk("t6_init",    int'(sa_init),    0);
        chk("t6_done",    int'(done_valid), 0);
        chk("t6_q_count", int'(q_count),    0);
        chk("t6_base_a",  int'(sa_base_a),  0);
        chk("t6_base_b",  int'(sa_base_b),  0);
        chk("t6_done_id", int'(done_id),    0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle_cycle(1'b1);
        chk("t6_after_idle", int'(busy),    0);
        chk("t6_after_q",    int'(q_count), 0);

        // Random traffic.
        clear_ev();
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'($urandom),
                  1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) != 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
